// File: rtl/roi_crop.sv
// ---------------------------------------------------------------------------
// roi_crop
//
// Crops an incoming pixel stream down to an inclusive rectangle described by
// two corner words from the ROI register block. Pixel position is tracked
// from the sof/eol markers. Only in-window pixels are forwarded, and sof/eol
// are regenerated for the cropped stream. All other pixels are consumed and
// dropped.
//
// Ports
//   clk_i, arst_ni          clock, async active-low reset
//   xy_0_i / xy_1_i         top-left / bottom-right corner words,
//                           x = [COORD_W-1:0], y = [16+COORD_W-1:16]
//   s_valid_i / s_ready_o   input handshake (s_data_i, s_sof_i, s_eol_i)
//   m_valid_o / m_ready_i   output handshake (m_data_o, m_sof_o, m_eol_o)
//   frame_done_o            one-cycle pulse after the last cropped pixel of
//                           a frame is accepted downstream
//
// COORD_W must be <= 16 so that the y field fits the corner word packing.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for sof; accepted pixels without sof are dropped
// ST_ACTIVE | inside a frame; position tracked, in-window pixels forwarded
// ---------------------------------------------------------------------------
module roi_crop #(
    parameter int DATA_W     = 24,
    parameter int COORD_W    = 10,
    parameter int APB_DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [APB_DATA_W-1:0] xy_0_i,
    input  logic [APB_DATA_W-1:0] xy_1_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_W-1:0]     s_data_i,
    input  logic                  s_sof_i,
    input  logic                  s_eol_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_W-1:0]     m_data_o,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  frame_done_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] x0_q, x0_d;
    logic [COORD_W-1:0] y0_q, y0_d;
    logic [COORD_W-1:0] x1_q, x1_d;
    logic [COORD_W-1:0] y1_q, y1_d;
    logic               sof_pend_q, sof_pend_d;

    logic               m_valid_q, m_valid_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               m_sof_q, m_sof_d;
    logic               m_eol_q, m_eol_d;
    logic               m_last_q, m_last_d;
    logic               frame_done_q, frame_done_d;

    logic               accept;
    logic               proc;
    logic [COORD_W-1:0] win_x0, win_y0, win_x1, win_y1;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic               in_win;
    logic               pend;
    logic               beat_eol;
    logic               beat_last;

    // Only the coordinate fields of the corner words are meaningful.
    logic unused_xy;
    assign unused_xy = ^{xy_0_i, xy_1_i};

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The output register is the only buffering; dropped pixels obey the
    // same ready rule so the input never runs ahead of a stalled output.
    assign s_ready_o = !m_valid_q || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign proc      = accept && ((state_q == ST_ACTIVE) || s_sof_i);

    // A pixel carrying sof is already judged against the corners it latches,
    // and sits at (0,0) regardless of where the counters were.
    always_comb begin
        win_x0 = x0_q;
        win_y0 = y0_q;
        win_x1 = x1_q;
        win_y1 = y1_q;
        cur_x  = x_q;
        cur_y  = y_q;
        pend   = sof_pend_q;
        if (s_sof_i) begin
            win_x0 = xy_0_i[COORD_W-1:0];
            win_y0 = xy_0_i[16 +: COORD_W];
            win_x1 = xy_1_i[COORD_W-1:0];
            win_y1 = xy_1_i[16 +: COORD_W];
            cur_x  = '0;
            cur_y  = '0;
            pend   = 1'b1;
        end
    end

    // An inverted corner pair can never satisfy both bounds, so an empty
    // window falls out of the compare without a special case.
    assign in_win    = (cur_x >= win_x0) && (cur_x <= win_x1) &&
                       (cur_y >= win_y0) && (cur_y <= win_y1);
    assign beat_eol  = (cur_x == win_x1) || s_eol_i;
    assign beat_last = beat_eol && (cur_y == win_y1);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        sof_pend_d   = sof_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_sof_d      = m_sof_q;
        m_eol_d      = m_eol_q;
        m_last_d     = m_last_q;
        frame_done_d = m_valid_q && m_ready_i && m_last_q;

        // Output register: reload whenever it is empty or being drained,
        // otherwise hold everything steady.
        if (s_ready_o) begin
            m_valid_d = proc && in_win;
            if (proc && in_win) begin
                m_data_d = s_data_i;
                m_sof_d  = pend;
                m_eol_d  = beat_eol;
                m_last_d = beat_last;
            end
        end

        if (proc) begin
            state_d = ST_ACTIVE;
            if (s_sof_i) begin
                x0_d = win_x0;
                y0_d = win_y0;
                x1_d = win_x1;
                y1_d = win_y1;
            end

            if (s_eol_i) begin
                x_d = '0;
                y_d = sat_inc(cur_y);
            end else begin
                x_d = sat_inc(cur_x);
                y_d = cur_y;
            end

            sof_pend_d = pend && !in_win;

            // Rest of the frame lies outside the window; park until next sof.
            if (in_win && beat_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            sof_pend_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            sof_pend_q   <= sof_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_sof_q      <= m_sof_d;
            m_eol_q      <= m_eol_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_sof_o      = m_sof_q;
    assign m_eol_o      = m_eol_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_roi_crop.sv
module tb_roi_crop;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic [31:0] xy0, xy1;
    logic        s_valid, s_sof, s_eol, s_ready;
    logic [23:0] s_data;
    logic        m_valid, m_ready, m_sof, m_eol, fdone;
    logic [23:0] m_data;

    logic ready_lvl;
    logic tog_en;
    logic tog = 1'b1;
    assign m_ready = tog_en ? tog : ready_lvl;
    always @(posedge clk) begin
        #1 tog = ~tog;
    end

    int asserts = 0;
    int fails   = 0;

    roi_crop #(.DATA_W(24), .COORD_W(10), .APB_DATA_W(32)) dut (
        .clk_i(clk), .arst_ni(arst_n),
        .xy_0_i(xy0), .xy_1_i(xy1),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .s_sof_i(s_sof), .s_eol_i(s_eol),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_sof_o(m_sof), .m_eol_o(m_eol), .frame_done_o(fdone)
    );

    // Output monitor: records every accepted beat, frame_done pulses and
    // any change of the m_* outputs while a beat is stalled.
    logic [23:0] cap_data [256];
    logic        cap_sof  [256];
    logic        cap_eol  [256];
    int          cap_n = 0;
    int          done_cnt = 0;
    int          done_idx = 0;
    int          viol = 0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data;
    logic        prev_sof, prev_eol;

    always @(negedge clk) begin
        if (fdone === 1'b1) begin
            done_cnt++;
            done_idx = cap_n;
        end
        if (prev_stall && (m_data !== prev_data || m_sof !== prev_sof ||
                           m_eol !== prev_eol || m_valid !== 1'b1))
            viol++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (cap_n < 256) begin
                cap_data[cap_n] = m_data;
                cap_sof[cap_n]  = m_sof;
                cap_eol[cap_n]  = m_eol;
            end
            cap_n++;
        end
        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        if (prev_stall) stall_cnt++;
        prev_data = m_data;
        prev_sof  = m_sof;
        prev_eol  = m_eol;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [23:0] d, input logic sof, input logic eol);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fails++;
            $display("FAIL send_timeout: s_ready stuck at %b, expected 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                send_pixel(24'(y * 8 + x), (x == 0 && y == 0), (x == w - 1));
    endtask

    task automatic test_reset;
        arst_n = 1'b0; xy0 = '0; xy1 = '0;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
        ready_lvl = 1'b1; tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        asserts++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
        asserts++; if (m_data !== 24'd0) begin fails++; $display("FAIL rst_m_data: got %0d expected 0", m_data); end
        asserts++; if (m_sof !== 1'b0) begin fails++; $display("FAIL rst_m_sof: got %b expected 0", m_sof); end
        asserts++; if (m_eol !== 1'b0) begin fails++; $display("FAIL rst_m_eol: got %b expected 0", m_eol); end
        asserts++; if (fdone !== 1'b0) begin fails++; $display("FAIL rst_frame_done: got %b expected 0", fdone); end
        arst_n = 1'b1;
        idle_cycles(1);
        asserts++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
        asserts++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_idle_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_basic_crop;
        int base, dbase, n;
        int exp_d [6];
        bit exp_s [6];
        bit exp_e [6];
        exp_d = '{10, 11, 12, 18, 19, 20};
        exp_s = '{1, 0, 0, 0, 0, 0};
        exp_e = '{0, 0, 1, 0, 0, 1};
        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0001_0002; xy1 = 32'h0002_0004;
        send_frame(8, 4);
        idle_cycles(6);
        n = cap_n - base;
        asserts++; if (n !== 6) begin fails++; $display("FAIL basic_count: got %0d expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
            asserts++; if (cap_sof[base+i] !== exp_s[i]) begin fails++; $display("FAIL basic_sof[%0d]: got %b expected %b", i, cap_sof[base+i], exp_s[i]); end
            asserts++; if (cap_eol[base+i] !== exp_e[i]) begin fails++; $display("FAIL basic_eol[%0d]: got %b expected %b", i, cap_eol[base+i], exp_e[i]); end
        end
        asserts++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - dbase); end
        asserts++; if (done_idx - base !== 6) begin fails++; $display("FAIL basic_done_after: got %0d beats expected 6", done_idx - base); end
    endtask

    task automatic test_backpressure;
        int base, dbase, vbase, sbase, n;
        int exp_d [6];
        bit exp_e [6];
        exp_d = '{10, 11, 12, 18, 19, 20};
        exp_e = '{0, 0, 1, 0, 0, 1};
        base = cap_n; dbase = done_cnt; vbase = viol; sbase = stall_cnt;
        xy0 = 32'h0001_0002; xy1 = 32'h0002_0004;
        tog_en = 1'b1;
        send_frame(8, 4);
        idle_cycles(10);
        tog_en = 1'b0;
        idle_cycles(2);
        n = cap_n - base;
        asserts++; if (n !== 6) begin fails++; $display("FAIL bp_count: got %0d expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
            asserts++; if (cap_eol[base+i] !== exp_e[i]) begin fails++; $display("FAIL bp_eol[%0d]: got %b expected %b", i, cap_eol[base+i], exp_e[i]); end
        end
        asserts++; if (cap_sof[base] !== 1'b1) begin fails++; $display("FAIL bp_sof: got %b expected 1", cap_sof[base]); end
        asserts++; if (viol - vbase !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", viol - vbase); end
        asserts++; if (stall_cnt - sbase < 1) begin fails++; $display("FAIL bp_stalls: got %0d stall cycles expected at least 1", stall_cnt - sbase); end
        asserts++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt - dbase); end
    endtask

    task automatic test_empty_window;
        int base, dbase;
        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0000_0005; xy1 = 32'h0003_0003;
        send_frame(8, 4);
        idle_cycles(5);
        asserts++; if (cap_n - base !== 0) begin fails++; $display("FAIL empty_count: got %0d expected 0", cap_n - base); end
        asserts++; if (done_cnt - dbase !== 0) begin fails++; $display("FAIL empty_done: got %0d expected 0", done_cnt - dbase); end
    endtask

    task automatic test_clipped_window;
        int base, dbase, n;
        int exp_d [3];
        bit exp_e [3];
        exp_d = '{13, 14, 15};
        exp_e = '{0, 0, 1};
        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0001_0005; xy1 = 32'h0001_03FF;
        send_frame(8, 4);
        idle_cycles(5);
        n = cap_n - base;
        asserts++; if (n !== 3) begin fails++; $display("FAIL clip_count: got %0d expected 3", n); end
        for (int i = 0; i < 3 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL clip_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
            asserts++; if (cap_eol[base+i] !== exp_e[i]) begin fails++; $display("FAIL clip_eol[%0d]: got %b expected %b", i, cap_eol[base+i], exp_e[i]); end
        end
        asserts++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL clip_done: got %0d expected 1", done_cnt - dbase); end
    endtask

    task automatic test_corner_update;
        int base, dbase, n;
        int exp_d [10];
        bit exp_s [10];
        bit exp_e [10];
        exp_d = '{10, 11, 12, 18, 19, 20, 10, 11, 18, 19};
        exp_s = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        exp_e = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0001_0002; xy1 = 32'h0002_0004;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                if (y == 1 && x == 3) xy1 = 32'h0002_0003;
                send_pixel(24'(y * 8 + x), (x == 0 && y == 0), (x == 7));
            end
        send_frame(8, 4);
        idle_cycles(5);
        n = cap_n - base;
        asserts++; if (n !== 10) begin fails++; $display("FAIL corner_count: got %0d expected 10", n); end
        for (int i = 0; i < 10 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL corner_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
            asserts++; if (cap_sof[base+i] !== exp_s[i]) begin fails++; $display("FAIL corner_sof[%0d]: got %b expected %b", i, cap_sof[base+i], exp_s[i]); end
            asserts++; if (cap_eol[base+i] !== exp_e[i]) begin fails++; $display("FAIL corner_eol[%0d]: got %b expected %b", i, cap_eol[base+i], exp_e[i]); end
        end
        asserts++; if (done_cnt - dbase !== 2) begin fails++; $display("FAIL corner_done: got %0d expected 2", done_cnt - dbase); end
    endtask

    task automatic test_resync;
        int base, dbase, n;
        int exp_d [9];
        bit exp_s [9];
        bit exp_e [9];
        exp_d = '{10, 11, 12, 10, 11, 12, 18, 19, 20};
        exp_s = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        exp_e = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        base = cap_n;
        xy0 = 32'h0000_0000; xy1 = 32'h0003_0007;
        for (int i = 0; i < 5; i++) send_pixel(24'(50 + i), 1'b0, (i == 2));
        idle_cycles(3);
        asserts++; if (cap_n - base !== 0) begin fails++; $display("FAIL presof_count: got %0d expected 0", cap_n - base); end

        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0001_0002; xy1 = 32'h0002_0004;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 8; x++)
                send_pixel(24'(y * 8 + x), (x == 0 && y == 0), (x == 7));
        send_frame(8, 4);
        idle_cycles(5);
        n = cap_n - base;
        asserts++; if (n !== 9) begin fails++; $display("FAIL midsof_count: got %0d expected 9", n); end
        for (int i = 0; i < 9 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL midsof_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
            asserts++; if (cap_sof[base+i] !== exp_s[i]) begin fails++; $display("FAIL midsof_sof[%0d]: got %b expected %b", i, cap_sof[base+i], exp_s[i]); end
            asserts++; if (cap_eol[base+i] !== exp_e[i]) begin fails++; $display("FAIL midsof_eol[%0d]: got %b expected %b", i, cap_eol[base+i], exp_e[i]); end
        end
        asserts++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL midsof_done: got %0d expected 1", done_cnt - dbase); end
    endtask

    task automatic test_sof_eol;
        int base, dbase, n;
        base = cap_n; dbase = done_cnt;
        xy0 = 32'h0001_0000; xy1 = 32'h0001_0001;
        send_pixel(24'd100, 1'b1, 1'b1);
        send_pixel(24'd1, 1'b0, 1'b0);
        send_pixel(24'd2, 1'b0, 1'b1);
        idle_cycles(4);
        n = cap_n - base;
        asserts++; if (n !== 2) begin fails++; $display("FAIL sofeol_count: got %0d expected 2", n); end
        if (n >= 2) begin
            asserts++; if (cap_data[base] !== 24'd1 || cap_sof[base] !== 1'b1 || cap_eol[base] !== 1'b0) begin fails++; $display("FAIL sofeol_beat0: got %0d sof=%b eol=%b expected 1 sof=1 eol=0", cap_data[base], cap_sof[base], cap_eol[base]); end
            asserts++; if (cap_data[base+1] !== 24'd2 || cap_sof[base+1] !== 1'b0 || cap_eol[base+1] !== 1'b1) begin fails++; $display("FAIL sofeol_beat1: got %0d sof=%b eol=%b expected 2 sof=0 eol=1", cap_data[base+1], cap_sof[base+1], cap_eol[base+1]); end
        end
        asserts++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL sofeol_done: got %0d expected 1", done_cnt - dbase); end
    endtask

    task automatic test_reset_mid;
        int base, n;
        int exp_d [6];
        exp_d = '{10, 11, 12, 18, 19, 20};
        xy0 = 32'h0000_0000; xy1 = 32'h0003_0007;
        ready_lvl = 1'b0;
        send_pixel(24'd77, 1'b1, 1'b0);
        idle_cycles(2);
        asserts++; if (m_valid !== 1'b1 || m_data !== 24'd77) begin fails++; $display("FAIL rmid_held: got valid=%b data=%0d expected valid=1 data=77", m_valid, m_data); end
        #2 arst_n = 1'b0;
        #1;
        asserts++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", m_valid); end
        asserts++; if (m_data !== 24'd0) begin fails++; $display("FAIL rmid_data: got %0d expected 0", m_data); end
        asserts++; if (m_sof !== 1'b0 || m_eol !== 1'b0 || fdone !== 1'b0) begin fails++; $display("FAIL rmid_flags: got sof=%b eol=%b done=%b expected all 0", m_sof, m_eol, fdone); end
        @(posedge clk);
        #1 arst_n = 1'b1;
        ready_lvl = 1'b1;
        idle_cycles(1);
        asserts++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rmid_s_ready: got %b expected 1", s_ready); end
        base = cap_n;
        xy0 = 32'h0001_0002; xy1 = 32'h0002_0004;
        send_frame(8, 4);
        idle_cycles(5);
        n = cap_n - base;
        asserts++; if (n !== 6) begin fails++; $display("FAIL rmid_count: got %0d expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            asserts++; if (cap_data[base+i] !== 24'(exp_d[i])) begin fails++; $display("FAIL rmid_data[%0d]: got %0d expected %0d", i, cap_data[base+i], exp_d[i]); end
        end
        asserts++; if (cap_sof[base] !== 1'b1) begin fails++; $display("FAIL rmid_sof: got %b expected 1", cap_sof[base]); end
    endtask

    initial begin
        test_reset();
        test_basic_crop();
        test_backpressure();
        test_empty_window();
        test_clipped_window();
        test_corner_update();
        test_resync();
        test_sof_eol();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
